hdc_feature_packer: RTL and testbench
=====================================

# hdc_feature_packer

Upstream front end of `hdc_sensor_fusion`. Accepts quantized sensor features one channel per cycle over a valid/ready stream and assembles them into full frames of `TOTAL_NUM_CHANNEL*CHANNEL_WIDTH` bits. Presents each completed frame on `features_top`/`fin_valid`/`fin_ready`, ready to connect directly to the fusion core. Two frame slots let the next frame fill while the core holds the current one, so serial input can stream without gaps.

## Interface
- `NUM_CHANNEL`, default `` `TOTAL_NUM_CHANNEL ``: channels per frame; must be ≥2.
- `CHANNEL_WIDTH`, default `` `CHANNEL_WIDTH ``: bits per channel sample.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in `CHANNEL_WIDTH`: one channel sample.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: packer can accept a sample this cycle.
- `in_last` in 1: marks the final channel of a frame. Used only when the configuration macro below is defined.
- `features_top` out `NUM_CHANNEL*CHANNEL_WIDTH`: assembled frame.
- `fin_valid` out 1: `features_top` holds a complete frame.
- `fin_ready` in 1: downstream accepts the frame.
- `frame_err` out 1: sticky framing error flag.

## Operation
- Storage:
  - Two frame slots `slot[0..1]`.
  - Write pointer `wr_ptr`, read pointer `rd_ptr`, and `full_cnt` (0..2).
  - Channel index `idx`, range 0..NUM_CHANNEL-1.
- Accept rule: a sample is accepted when `in_valid && in_ready`. It is written to `slot[wr_ptr][idx*CHANNEL_WIDTH +: CHANNEL_WIDTH]`, so channel 0 occupies the LSBs.
- `in_ready = !rst && full_cnt < 2 && state != RESYNC_BLOCKED`. There is no blocked state in this design, so effectively `in_ready = !rst && full_cnt < 2`.
- Frame commit: when a sample is accepted with `idx == NUM_CHANNEL-1`:
  - `idx` wraps to 0.
  - `wr_ptr` toggles.
  - `full_cnt` increments.
- Output side:
  - `fin_valid = (full_cnt != 0)`.
  - `features_top = slot[rd_ptr]`.
  - On `fin_valid && fin_ready`, `rd_ptr` toggles and `full_cnt` decrements.
- Simultaneous commit and drain in the same cycle: `full_cnt` is unchanged and both pointers toggle.
- `features_top` and `fin_valid` stay stable while `fin_valid && !fin_ready`.
- State machine (used only when the macro is defined): `FILL` and `RESYNC`.
  - `FILL`, early last: `in_last=1` accepted with `idx != NUM_CHANNEL-1`. The partial frame is discarded, `idx` goes to 0, `frame_err` is set, and the state stays `FILL`.
  - `FILL`, missing last: `in_last=0` accepted with `idx == NUM_CHANNEL-1`. No commit, `frame_err` is set, and the state moves to `RESYNC`.
  - `RESYNC`: accepted samples are dropped (still handshaken, so `in_ready` follows the normal rule). An accepted sample with `in_last=1` sets `idx` to 0 and returns the state to `FILL`.
- `frame_err` stays set until reset.
- Reset values:
  - `fin_valid=0`, `in_ready=0` during `rst`, `frame_err=0`, `features_top=0`.
  - Both slots, all pointers, `full_cnt` and `idx` cleared; state `FILL`.
- Reset mid-frame: the partial frame and both buffered frames are lost. No frame is emitted after reset until a full new frame arrives.

## Timing
- Input throughput: 1 sample/cycle while `full_cnt < 2`.
- Latency: `fin_valid` rises in the cycle after the edge that accepts the last channel.
- Output throughput: 1 frame/cycle when `full_cnt` allows. Sustained rate is NUM_CHANNEL cycles/frame, limited by the input.
- Full: with 2 frames held, `in_ready=0`. It returns high in the cycle after a `fin` handshake.
- `in_ready` depends only on registered state, never combinationally on `fin_ready`.
- `fin_valid` depends only on registered state, never combinationally on `in_valid`.
- `in_ready` rises in the first cycle after `rst` deasserts.

## Configuration
- `HDC_PACKER_LAST_CHECK_EN`:
  - Defined: `in_last` is checked, the `FILL`/`RESYNC` state machine is active, and `frame_err` operates as described.
  - Undefined: `in_last` is ignored, frames are delimited by count alone, the state stays `FILL`, and `frame_err` is tied 0.

## Test plan
All scenarios use NUM_CHANNEL=4 and CHANNEL_WIDTH=8.
- Back-to-back frames: stream 0x01..0x04 with `fin_ready=1`, last on the 4th sample → `fin_valid` one cycle after the 4th accept; `features_top=0x04030201`.
- Backpressure: `fin_ready=0`, send 3 frames → after 8 accepts `in_ready=0`; frames 1 and 2 are held stable; raising `fin_ready` drains them in order and `in_ready` returns the next cycle.
- Simultaneous: last sample of frame 2 accepted in the same cycle as the frame 1 handshake → `full_cnt` stays 1; frame 2 is presented the next cycle.
- Early last (macro on): `in_last` on the 2nd sample → no `fin_valid`, `frame_err=1`; the next 4 samples form a correct frame.
- Missing last (macro on): 4 samples without last → no output, `frame_err=1`; samples are dropped until one with `in_last=1`; the next 4 samples pack correctly. With the macro off, the same stimulus emits a frame and `frame_err=0`.
- Reset after 2 samples, then send 0xA0..0xA3 → single frame `0xA3A2A1A0`; no stale data.

Source files
------------

// File: rtl/hdc_feature_packer_if.sv
// ============================================================================
// Module   : hdc_feature_packer_if
// Brief    : Sample-in / frame-out stream bundle for hdc_feature_packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif

interface hdc_feature_packer_if #(
    parameter int NUM_CHANNEL   = `TOTAL_NUM_CHANNEL,
    parameter int CHANNEL_WIDTH = `CHANNEL_WIDTH
);
    logic [CHANNEL_WIDTH-1:0]             in_data;
    logic                                 in_valid;
    logic                                 in_ready;
    logic                                 in_last;
    logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top;
    logic                                 fin_valid;
    logic                                 fin_ready;
    logic                                 frame_err;

    // Master is the environment around the packer: sample source and frame sink.
    modport master (
        output in_data, in_valid, in_last, fin_ready,
        input  in_ready, features_top, fin_valid, frame_err
    );

    modport slave (
        input  in_data, in_valid, in_last, fin_ready,
        output in_ready, features_top, fin_valid, frame_err
    );
endinterface

`default_nettype wire

// File: rtl/hdc_feature_packer.sv
// ============================================================================
// Module   : hdc_feature_packer
// Brief    : Packs serial channel samples into double-buffered full frames.
//            Optional macro HDC_PACKER_LAST_CHECK_EN enables in_last framing
//            checks with a FILL/RESYNC state machine and sticky frame_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif

module hdc_feature_packer #(
    parameter int NUM_CHANNEL   = `TOTAL_NUM_CHANNEL,
    parameter int CHANNEL_WIDTH = `CHANNEL_WIDTH
) (
    input  wire logic            clk,
    input  wire logic            rst,
    hdc_feature_packer_if.slave  bus
);
    localparam int IDX_W = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNEL - 1);

    typedef logic [NUM_CHANNEL-1:0][CHANNEL_WIDTH-1:0] frame_t;

    frame_t           r_slot [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_full_cnt;
    logic [IDX_W-1:0] r_idx;

    logic w_accept;
    logic w_at_last;
    logic w_store;
    logic w_commit;
    logic w_idx_clear;
    logic w_drain;

    assign bus.in_ready     = !rst && (r_full_cnt != 2'd2);
    assign bus.fin_valid    = (r_full_cnt != 2'd0);
    assign bus.features_top = r_slot[r_rd_ptr];

    assign w_accept  = bus.in_valid && bus.in_ready;
    assign w_at_last = (r_idx == LAST_IDX);
    assign w_drain   = bus.fin_valid && bus.fin_ready;

`ifdef HDC_PACKER_LAST_CHECK_EN
    typedef enum logic [0:0] {
        FILL   = 1'b0,
        RESYNC = 1'b1
    } state_t;

    state_t r_state;
    logic   r_frame_err;

    // Missing-last also clears idx so RESYNC always restarts from channel 0.
    assign w_store     = w_accept && (r_state == FILL);
    assign w_commit    = w_store && w_at_last && bus.in_last;
    assign w_idx_clear = w_at_last || bus.in_last;
    assign bus.frame_err = r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_frame_err <= 1'b0;
        end else if (w_store) begin
            if (bus.in_last && !w_at_last) begin
                r_frame_err <= 1'b1;
            end else if (!bus.in_last && w_at_last) begin
                r_frame_err <= 1'b1;
                r_state     <= RESYNC;
            end
        end else if (w_accept && bus.in_last) begin
            r_state <= FILL;
        end
    end
`else
    assign w_store       = w_accept;
    assign w_commit      = w_store && w_at_last;
    assign w_idx_clear   = w_at_last;
    assign bus.frame_err = 1'b0;
`endif

    // The slot under wr_ptr is never one that is being presented while full_cnt < 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot[0]  <= '0;
            r_slot[1]  <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_full_cnt <= 2'd0;
            r_idx      <= '0;
        end else begin
            if (w_store) begin
                r_slot[r_wr_ptr][r_idx] <= bus.in_data;
                r_idx <= w_idx_clear ? '0 : r_idx + 1'b1;
            end
            if (w_commit) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_drain) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_commit, w_drain})
                2'b10:   r_full_cnt <= r_full_cnt + 2'd1;
                2'b01:   r_full_cnt <= r_full_cnt - 2'd1;
                default: r_full_cnt <= r_full_cnt;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_hdc_feature_packer.sv
// Scoreboarded bench for hdc_feature_packer: random + directed streams checked
// against a frame-level reference model (NUM_CHANNEL=4, CHANNEL_WIDTH=8).
`default_nettype none

module tb_hdc_feature_packer;
    localparam int NC = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hdc_feature_packer_if #(.NUM_CHANNEL(NC), .CHANNEL_WIDTH(CW)) bus ();

    hdc_feature_packer #(.NUM_CHANNEL(NC), .CHANNEL_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [NC*CW-1:0] exp_q [$];
    logic [CW-1:0]    part  [$];
    int               held  = 0;
    bit               m_err = 1'b0;
`ifdef HDC_PACKER_LAST_CHECK_EN
    bit               m_resync = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void emit();
        logic [NC*CW-1:0] f = '0;
        for (int i = 0; i < NC; i++) f[i*CW +: CW] = part[i];
        exp_q.push_back(f);
        held++;
        part.delete();
    endfunction

    function automatic void model_accept(input logic [CW-1:0] d, input bit l);
`ifdef HDC_PACKER_LAST_CHECK_EN
        if (m_resync) begin
            if (l) m_resync = 1'b0;
            return;
        end
        part.push_back(d);
        if (part.size() == NC) begin
            if (l) emit();
            else begin
                m_err = 1'b1;
                m_resync = 1'b1;
                part.delete();
            end
        end else if (l) begin
            m_err = 1'b1;
            part.delete();
        end
`else
        part.push_back(d);
        if (l || !l) begin
            if (part.size() == NC) emit();
        end
`endif
    endfunction

    // Monitor: pops expected frames on every fin handshake and checks hold stability.
    initial begin
        logic [NC*CW-1:0] prev;
        bit hold;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (hold) begin
                check("hold_fin_valid", bus.fin_valid, 1'b1);
                check("hold_features", bus.features_top, prev);
            end
            hold = !rst && bus.fin_valid && !bus.fin_ready;
            prev = bus.features_top;
            if (!rst && bus.fin_valid && bus.fin_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_frame actual=%0h required=none", bus.features_top);
                end else begin
                    check("frame_data", bus.features_top, exp_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input bit v, input logic [CW-1:0] d, input bit l, input bit fr, output bit acc);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.fin_ready = fr;
        @(negedge clk);
        check("in_ready", bus.in_ready, held < 2);
        check("fin_valid", bus.fin_valid, held != 0);
        check("frame_err", bus.frame_err, m_err);
        if (bus.fin_valid && bus.fin_ready) held--;
        acc = v && bus.in_ready;
        if (acc) model_accept(d, l);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit fr);
        bit acc;
        cycle(1'b0, '0, 1'b0, fr, acc);
    endtask

    task automatic send(input logic [CW-1:0] d, input bit l, input bit fr);
        bit acc = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) cycle(1'b1, d, l, fr, acc);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled required=accept data=%0h", d);
        end
    endtask

    task automatic send_frame(input logic [CW-1:0] base, input bit fr);
        for (int i = 0; i < NC; i++) send(base + CW'(i), i == NC - 1, fr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.fin_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready_low", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_fin_valid", bus.fin_valid, 1'b0);
        check("rst_features", bus.features_top, '0);
        check("rst_frame_err", bus.frame_err, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        exp_q.delete();
        part.delete();
        held  = 0;
        m_err = 1'b0;
`ifdef HDC_PACKER_LAST_CHECK_EN
        m_resync = 1'b0;
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        do_reset();

        // Back-to-back frame 0x04030201 with the sink always ready.
        send_frame(8'h01, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: two frames fill both slots, third waits until drain.
        send_frame(8'h10, 1'b0);
        send_frame(8'h20, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b0);
        send_frame(8'h30, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Commit of frame 2 coincides with the drain of frame 1.
        send_frame(8'h40, 1'b0);
        for (int i = 0; i < NC - 1; i++) send(8'h50 + 8'(i), 1'b0, 1'b0);
        send(8'h53, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Early last, then a good frame.
        send(8'h61, 1'b0, 1'b1);
        send(8'h62, 1'b1, 1'b1);
        send_frame(8'h70, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Missing last, dropped samples, terminating last, then a good frame.
        for (int i = 0; i < NC; i++) send(8'h80 + 8'(i), 1'b0, 1'b1);
        send(8'h90, 1'b0, 1'b1);
        send(8'h91, 1'b1, 1'b1);
        send_frame(8'hB0, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Randomized phase: mostly well-framed, occasional framing slips.
        for (int n = 0; n < 600; n++) begin
            bit v, l, fr;
            logic [CW-1:0] d;
            v  = ($urandom % 4) != 0;
            d  = CW'($urandom);
            l  = (part.size() == NC - 1) ^ (($urandom % 16) == 0);
            fr = ($urandom % 3) != 0;
            cycle(v, d, l, fr, acc);
        end

        // Reset mid-frame, then a clean frame with no stale data.
        send(8'hC0, 1'b0, 1'b1);
        send(8'hC1, 1'b0, 1'b1);
        do_reset();
        send_frame(8'hA0, 1'b1);

        for (int t = 0; t < 20 && held != 0; t++) idle(1'b1);
        idle(1'b1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
